// File: rtl/trigger_capture.sv
// Scope capture writer: decimates the ADC stream, detects a level/edge trigger
// and writes one DEPTH-sample frame into display memory, re-arming only at vsync.
module trigger_capture #(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned DEPTH        = 640,
  parameter int unsigned DECIM_W      = 8,
  parameter int unsigned AUTO_TIMEOUT = 100000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sample_valid,
  input  logic [DATA_W-1:0]  i_sample,
  input  logic [DECIM_W-1:0] i_decim,
  input  logic [DATA_W-1:0]  i_trig_level,
  input  logic               i_trig_falling,
  input  logic               i_auto,
  input  logic               i_single,
  input  logic               i_arm,
  input  logic               i_stop,
  input  logic               i_vsync,
  output logic               o_wr_en,
  output logic [9:0]         o_wr_addr,
  output logic [DATA_W-1:0]  o_wr_data,
  output logic               o_frame_done,
  output logic               o_triggered,
  output logic               o_armed
);

  localparam int unsigned     TO_W      = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
  localparam logic [9:0]      LAST_ADDR = 10'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLDOFF} state_e;

  state_e             state_q;
  logic [DECIM_W-1:0] dcnt_q;
  logic [TO_W-1:0]    tcnt_q;
  logic [DATA_W-1:0]  prev_q;
  logic               prev_valid_q;
  logic [9:0]         waddr_q;

  logic taken;
  logic rise_hit;
  logic fall_hit;
  logic edge_hit;
  logic force_hit;

  always_comb begin
    taken     = i_sample_valid && (state_q != IDLE) && (dcnt_q == '0);
    rise_hit  = prev_valid_q && (prev_q < i_trig_level) && (i_sample >= i_trig_level);
    fall_hit  = prev_valid_q && (prev_q > i_trig_level) && (i_sample <= i_trig_level);
    edge_hit  = i_trig_falling ? fall_hit : rise_hit;
    force_hit = i_auto && (tcnt_q == TO_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      dcnt_q       <= '0;
      tcnt_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      waddr_q      <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_triggered  <= 1'b0;
      o_armed      <= 1'b0;
    end else begin
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      // Stop overrides everything; the write already on the outputs has been seen.
      if (i_stop) begin
        state_q     <= IDLE;
        o_triggered <= 1'b0;
        o_armed     <= 1'b0;
      end else begin
        if (state_q != IDLE && i_sample_valid)
          dcnt_q <= (dcnt_q == i_decim) ? '0 : dcnt_q + 1'b1;

        unique case (state_q)
          IDLE: begin
            if (i_arm) begin
              state_q      <= ARMED;
              dcnt_q       <= '0;
              tcnt_q       <= '0;
              prev_valid_q <= 1'b0;
              o_armed      <= 1'b1;
              o_triggered  <= 1'b0;
            end
          end
          ARMED: begin
            if (taken) begin
              prev_q       <= i_sample;
              prev_valid_q <= 1'b1;
              if (tcnt_q != TO_LAST)
                tcnt_q <= tcnt_q + 1'b1;
              if (edge_hit || force_hit) begin
                state_q     <= CAPTURE;
                o_armed     <= 1'b0;
                o_triggered <= 1'b1;
                o_wr_en     <= 1'b1;
                o_wr_addr   <= '0;
                o_wr_data   <= i_sample;
                waddr_q     <= 10'd1;
              end
            end
          end
          CAPTURE: begin
            if (taken) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= waddr_q;
              o_wr_data <= i_sample;
              waddr_q   <= waddr_q + 10'd1;
              if (waddr_q == LAST_ADDR) begin
                o_frame_done <= 1'b1;
                state_q      <= HOLDOFF;
              end
            end
          end
          HOLDOFF: begin
            if (i_vsync) begin
              o_triggered <= 1'b0;
              if (i_single) begin
                state_q <= IDLE;
              end else begin
                state_q      <= ARMED;
                dcnt_q       <= '0;
                tcnt_q       <= '0;
                prev_valid_q <= 1'b0;
                o_armed      <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// Randomized scoreboard bench for trigger_capture: a frame-level model predicts
// every memory write from the sample list; a monitor checks writes as they appear.
module tb_trigger_capture;

  localparam int DEPTH   = 640;
  localparam int AUTO_TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_sample_valid = 1'b0;
  logic [9:0] i_sample = '0;
  logic [7:0] i_decim = '0;
  logic [9:0] i_trig_level = '0;
  logic       i_trig_falling = 1'b0;
  logic       i_auto = 1'b0;
  logic       i_single = 1'b0;
  logic       i_arm = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_vsync = 1'b0;
  logic       o_wr_en;
  logic [9:0] o_wr_addr;
  logic [9:0] o_wr_data;
  logic       o_frame_done;
  logic       o_triggered;
  logic       o_armed;

  trigger_capture #(
    .DATA_W(10), .DEPTH(DEPTH), .DECIM_W(8), .AUTO_TIMEOUT(AUTO_TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(i_sample_valid),
    .i_sample(i_sample), .i_decim(i_decim), .i_trig_level(i_trig_level),
    .i_trig_falling(i_trig_falling), .i_auto(i_auto), .i_single(i_single),
    .i_arm(i_arm), .i_stop(i_stop), .i_vsync(i_vsync),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_done(o_frame_done), .o_triggered(o_triggered), .o_armed(o_armed)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data; bit last;} wr_t;
  wr_t exp_q[$];
  int  stim[$];
  int  pass_cnt = 0;
  int  chk_cnt  = 0;

  function automatic void check(string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", int'(o_wr_addr), -1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", int'(o_wr_addr), e.addr);
          check("wr_data", int'(o_wr_data), e.data);
          check("frame_done", int'(o_frame_done), int'(e.last));
          check("triggered_during_write", int'(o_triggered), 1);
        end
      end else if (o_frame_done) begin
        check("frame_done_without_write", 1, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame-level model: list taken samples, find the first trigger (or auto force),
  // and expect the next DEPTH taken samples at consecutive addresses.
  task automatic predict(input int decim, input int level, input bit falling,
                         input bit aut, input int max_wr, output int trig_k);
    int taken_k[$];
    trig_k = -1;
    for (int k = 0; k < stim.size(); k += decim + 1) taken_k.push_back(k);
    for (int i = 0; i < taken_k.size(); i++) begin
      int cur;
      int p;
      bit hit;
      cur = stim[taken_k[i]];
      hit = 1'b0;
      if (i > 0) begin
        p   = stim[taken_k[i-1]];
        hit = falling ? (p > level && cur <= level) : (p < level && cur >= level);
      end
      if (aut && i == AUTO_TO - 1) hit = 1'b1;
      if (hit) begin
        trig_k = taken_k[i];
        for (int j = 0; j < DEPTH && j < max_wr && i + j < taken_k.size(); j++)
          exp_q.push_back('{addr: j, data: stim[taken_k[i+j]], last: (j == DEPTH - 1)});
        break;
      end
    end
  endtask

  task automatic arm_with(input int decim, input int level, input bit falling,
                          input bit aut, input bit single);
    i_decim        = 8'(decim);
    i_trig_level   = 10'(level);
    i_trig_falling = falling;
    i_auto         = aut;
    i_single       = single;
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
    check("armed_after_arm", int'(o_armed), 1);
  endtask

  task automatic drive(input bit gaps, input int stop_k, input int arm_k);
    for (int k = 0; k < stim.size(); k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_sample_valid = 1'b0;
        i_sample       = 10'($urandom_range(0, 1023));
        repeat ($urandom_range(1, 3)) step();
      end
      i_sample_valid = 1'b1;
      i_sample       = 10'(stim[k]);
      i_stop         = (k == stop_k);
      i_arm          = (k == arm_k);
      step();
      i_sample_valid = 1'b0;
      i_stop         = 1'b0;
      i_arm          = 1'b0;
    end
  endtask

  task automatic drain(string name);
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) step();
    step();
    check(name, exp_q.size(), 0);
  endtask

  task automatic finish_frame(input bit single);
    check("holdoff_triggered", int'(o_triggered), 1);
    check("holdoff_not_armed", int'(o_armed), 0);
    i_vsync = 1'b1;
    step();
    i_vsync = 1'b0;
    check("vsync_rearm", int'(o_armed), int'(!single));
    check("vsync_trig_clear", int'(o_triggered), 0);
    if (!single) begin
      i_stop = 1'b1;
      step();
      i_stop = 1'b0;
      check("stop_to_idle", int'(o_armed), 0);
    end
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int k = 0; k < n; k++) stim.push_back(int'($urandom_range(0, 1023)));
  endtask

  initial begin
    int t;
    int d;
    int lvl;
    bit fe;
    bit sg;

    // reset held with activity on the inputs
    for (int c = 0; c < 6; c++) begin
      i_arm          = 1'($urandom_range(0, 1));
      i_sample_valid = 1'b1;
      i_sample       = 10'($urandom_range(0, 1023));
      i_auto         = 1'b1;
      step();
      check("reset_outputs_zero",
            int'({o_wr_en, o_armed, o_triggered, o_frame_done, |o_wr_addr, |o_wr_data}), 0);
    end
    i_arm = 1'b0;
    i_sample_valid = 1'b0;
    i_auto = 1'b0;
    rst_n = 1'b1;
    step();
    check("idle_after_reset", int'(o_armed), 0);

    // arm and stop together: stop wins
    i_arm = 1'b1;
    i_stop = 1'b1;
    step();
    i_arm = 1'b0;
    i_stop = 1'b0;
    check("arm_stop_same_cycle", int'(o_armed), 0);

    // rising ramp through 512, arm pulse mid-capture must be ignored
    stim = '{500, 505, 510, 515};
    for (int k = 0; k < 700; k++) stim.push_back(int'($urandom_range(0, 1023)));
    arm_with(0, 512, 1'b0, 1'b0, 1'b0);
    predict(0, 512, 1'b0, 1'b0, DEPTH, t);
    check("model_rise_trigger_index", t, 3);
    drive(1'b0, -1, t + 100);
    drain("rise_frame_complete");
    finish_frame(1'b0);

    // falling, first sample below level must not trigger; single shot
    stim = '{200, 310, 290};
    for (int k = 0; k < 700; k++) stim.push_back(int'($urandom_range(0, 1023)));
    arm_with(0, 300, 1'b1, 1'b0, 1'b1);
    predict(0, 300, 1'b1, 1'b0, DEPTH, t);
    drive(1'b1, -1, -1);
    drain("fall_frame_complete");
    finish_frame(1'b1);
    rand_stim(60);
    drive(1'b1, -1, -1);
    drain("idle_after_single_no_writes");

    // decimation by 4 with gaps in sample_valid
    rand_stim(2800);
    lvl = int'($urandom_range(100, 900));
    arm_with(3, lvl, 1'b0, 1'b1, 1'b0);
    predict(3, lvl, 1'b0, 1'b1, DEPTH, t);
    drive(1'b1, -1, -1);
    drain("decim_frame_complete");
    finish_frame(1'b0);

    // auto force on flat input
    stim.delete();
    for (int k = 0; k < 700; k++) stim.push_back(100);
    arm_with(0, 512, 1'b0, 1'b1, 1'b0);
    predict(0, 512, 1'b0, 1'b1, DEPTH, t);
    check("model_auto_index", t, AUTO_TO - 1);
    drive(1'b0, -1, -1);
    drain("auto_frame_complete");
    finish_frame(1'b0);

    // same flat input without auto stays armed
    stim.delete();
    for (int k = 0; k < 60; k++) stim.push_back(100);
    arm_with(0, 512, 1'b0, 1'b0, 1'b0);
    predict(0, 512, 1'b0, 1'b0, DEPTH, t);
    drive(1'b1, -1, -1);
    drain("no_auto_no_writes");
    check("no_auto_still_armed", int'(o_armed), 1);
    check("no_auto_not_triggered", int'(o_triggered), 0);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;

    // abort after the addr 300 write
    rand_stim(700);
    arm_with(0, 512, 1'b0, 1'b1, 1'b0);
    predict(0, 512, 1'b0, 1'b1, 301, t);
    drive(1'b0, t + 301, -1);
    drain("abort_writes_through_300");
    check("abort_not_armed", int'(o_armed), 0);
    check("abort_not_triggered", int'(o_triggered), 0);
    rand_stim(100);
    drive(1'b1, -1, -1);
    drain("abort_idle_no_writes");

    // randomized acquisitions
    for (int r = 0; r < 3; r++) begin
      d   = int'($urandom_range(0, 2));
      lvl = int'($urandom_range(50, 970));
      fe  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      rand_stim((d + 1) * (AUTO_TO + DEPTH + 10));
      arm_with(d, lvl, fe, 1'b1, sg);
      predict(d, lvl, fe, 1'b1, DEPTH, t);
      drive(1'b1, -1, -1);
      drain("rand_frame_complete");
      finish_frame(sg);
    end

    // asynchronous reset mid-capture abandons the frame
    rand_stim(700);
    arm_with(0, 512, 1'b0, 1'b1, 1'b0);
    predict(0, 512, 1'b0, 1'b1, 50, t);
    while (stim.size() > t + 50) void'(stim.pop_back());
    drive(1'b0, -1, -1);
    check("triggered_before_reset", int'(o_triggered), 1);
    check("write_pending_before_reset", int'(o_wr_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clears_outputs",
          int'({o_wr_en, o_armed, o_triggered, o_frame_done, |o_wr_addr, |o_wr_data}), 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    rand_stim(40);
    drive(1'b1, -1, -1);
    drain("post_reset_idle_no_writes");
    check("post_reset_not_armed", int'(o_armed), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
